memory_stage_hs: RTL and testbench

Parametrised successor to the combinational memory stage. Adds byte/half/word(/double) access with lane steering and sign/zero extension, and a req/ack handshake to a memory with variable latency. Adds a pipeline stall output and misalignment detection. Sits between execute and writeback; registers its result for writeback.

---
 rtl/memory_stage_hs.sv | 261 ++++++++++++++++++++++++++
 tb/tb_memory_stage_hs.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage_hs.sv
// memory_stage_hs -- memory access stage between execute and writeback.
//
// Purpose: turns one instruction from execute into a result for writeback.
// Non-memory instructions pass alu_result through with one cycle of latency.
// Loads and stores of byte/half/word(/double) size are checked for
// legality, then issued to a variable-latency memory over a req/ack
// handshake. The stage stalls upstream while the access is outstanding.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   valid_in        instruction present this cycle (held by upstream while stall=1)
//   alu_result      effective address, or pass-through result
//   reg_data        store source data
//   mem_op          2'd0 skip, 2'd1 load, 2'd2 store (2'd3 reserved, treated as skip)
//   mem_size        00 byte, 01 half, 10 word, 11 double (double only when XLEN=64)
//   mem_unsigned    1 = zero-extend loads, 0 = sign-extend loads
//   stall           combinational: upstream must hold its inputs
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   registered memory request
//   mem_ack, mem_rdata                           memory completion and read data
//   valid_out       one-cycle result pulse
//   write_out       writeback value, held until the next result
//   fault           accompanies valid_out: misaligned, illegal size or timeout
//   dbg_state       FSM state for observation: 0 = IDLE, 1 = BUSY
//
// Handshake: the memory holds a request for every cycle mem_req=1; the cycle
// in which mem_ack=1 completes it. Every mem_* output is stable from the
// request until that ack cycle. mem_ack is ignored outside BUSY.
//
// Optional feature (macro MEM_TIMEOUT_EN): when defined, a request that sees
// no ack for MAX_WAIT BUSY cycles is abandoned and reported with fault=1.
module memory_stage_hs #(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid_in,
    input  logic [XLEN-1:0]     alu_result,
    input  logic [XLEN-1:0]     reg_data,
    input  logic [1:0]          mem_op,
    input  logic [1:0]          mem_size,
    input  logic                mem_unsigned,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [XLEN/8-1:0]   mem_wstrb,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata,
    output logic                valid_out,
    output logic [XLEN-1:0]     write_out,
    output logic                fault,
    output logic                dbg_state
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    localparam logic [1:0] MEM_LOAD_OP  = 2'd1;
    localparam logic [1:0] MEM_STORE_OP = 2'd2;

    localparam logic [XLEN-1:0] ONE_X  = 1;
    localparam logic [NB-1:0]   ONE_NB = 1;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]     mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]       mem_wstrb_q, mem_wstrb_d;
    logic                valid_out_q, valid_out_d;
    logic [XLEN-1:0]     write_out_q, write_out_d;
    logic                fault_q, fault_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;

    // Request decode (IDLE side)
    logic                is_mem;
    logic                size_ok;
    logic                misaligned;
    logic                legal;
    logic [OFF_W-1:0]    req_off;
    logic [3:0]          size_bytes;
    logic [OFF_W-1:0]    align_mask;
    logic [ADDR_W-1:0]   addr_ext;
    logic [NB-1:0]       strb;
    logic [XLEN-1:0]     chunk;
    logic [XLEN-1:0]     wdata_rep;
    int                  sb;

    // Load return path (BUSY side)
    logic [3:0]          ld_bytes;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     ld_mask;
    logic [XLEN-1:0]     sign_tmp;
    logic                ld_sign;
    logic [XLEN-1:0]     load_val;

    // Reserved encoding 2'd3 falls through as a pass-through instruction.
    assign is_mem     = valid_in & ((mem_op == MEM_LOAD_OP) | (mem_op == MEM_STORE_OP));
    assign size_ok    = !((mem_size == 2'd3) && (XLEN == 32));
    assign req_off    = alu_result[OFF_W-1:0];
    assign size_bytes = 4'd1 << mem_size;
    assign align_mask = OFF_W'(size_bytes - 4'd1);
    assign misaligned = |(req_off & align_mask);
    assign legal      = size_ok & ~misaligned;

    assign stall = (state_q == BUSY) | ((state_q == IDLE) & is_mem & legal);

    assign addr_ext = ADDR_W'(alu_result);

    // A shift by the full vector width yields zero, so subtracting one gives
    // an all-ones mask for the widest access without a special case.
    assign strb = ((ONE_NB << size_bytes) - ONE_NB) << req_off;

    always_comb begin
        sb        = int'(size_bytes);
        chunk     = reg_data & ((ONE_X << {size_bytes, 3'b000}) - ONE_X);
        wdata_rep = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i % sb) == 0) begin
                wdata_rep = wdata_rep | (chunk << (8 * i));
            end
        end
    end

    always_comb begin
        ld_bytes = 4'd1 << size_q;
        shifted  = mem_rdata >> {off_q, 3'b000};
        ld_mask  = (ONE_X << {ld_bytes, 3'b000}) - ONE_X;
        sign_tmp = shifted >> ({ld_bytes, 3'b000} - 7'd1);
        ld_sign  = sign_tmp[0] & ~uns_q;
        load_val = (shifted & ld_mask) | (ld_sign ? ~ld_mask : '0);
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout;
    // Reaching MAX_WAIT on this cycle's increment ends the wait.
    assign timeout = (cnt_q == CNT_W'(MAX_WAIT - 1));
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        valid_out_d = 1'b0;
        write_out_d = write_out_q;
        fault_d     = fault_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (!is_mem) begin
                        valid_out_d = 1'b1;
                        write_out_d = alu_result;
                        fault_d     = 1'b0;
                    end else if (!legal) begin
                        valid_out_d = 1'b1;
                        write_out_d = '0;
                        fault_d     = 1'b1;
                    end else begin
                        state_d     = BUSY;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (mem_op == MEM_STORE_OP);
                        mem_addr_d  = addr_ext & ~ADDR_W'(NB - 1);
                        mem_wdata_d = (mem_op == MEM_STORE_OP) ? wdata_rep : '0;
                        mem_wstrb_d = (mem_op == MEM_STORE_OP) ? strb : '0;
                        off_d       = req_off;
                        size_d      = mem_size;
                        uns_d       = mem_unsigned;
                    end
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    valid_out_d = 1'b1;
                    fault_d     = 1'b0;
                    write_out_d = mem_we_q ? '0 : load_val;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    state_d     = IDLE;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    valid_out_d = 1'b1;
                    fault_d     = 1'b1;
                    write_out_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            valid_out_q <= 1'b0;
            write_out_q <= '0;
            fault_q     <= 1'b0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            valid_out_q <= valid_out_d;
            write_out_q <= write_out_d;
            fault_q     <= fault_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign valid_out = valid_out_q;
    assign write_out = write_out_q;
    assign fault     = fault_q;
    assign dbg_state = (state_q == BUSY);

endmodule

// File: tb/tb_memory_stage_hs.sv
// Testbench for memory_stage_hs (XLEN=32). Inputs change and outputs are
// sampled on the falling clock edge; the design acts on the rising edge.
module tb_memory_stage_hs;
    localparam int XLEN = 32;
    localparam int ADDR_W = 32;
    localparam int MAX_WAIT = 15;
    localparam logic [1:0] OP_SKIP = 2'd0, OP_LOAD = 2'd1, OP_STORE = 2'd2;

    logic clk, rst, valid_in, mem_unsigned, stall, mem_req, mem_we, mem_ack;
    logic valid_out, fault, dbg_state;
    logic [XLEN-1:0] alu_result, reg_data, mem_wdata, mem_rdata, write_out;
    logic [1:0] mem_op, mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN/8-1:0] mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;
    logic [XLEN:0] exp_q[$];  // {fault, write_out}

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    memory_stage_hs #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result),
        .reg_data(reg_data), .mem_op(mem_op), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .valid_out(valid_out), .write_out(write_out), .fault(fault),
        .dbg_state(dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        valid_in = 1'b0; mem_op = OP_SKIP; alu_result = '0; reg_data = '0;
        mem_size = 2'd0; mem_unsigned = 1'b0;
    endtask

    task automatic present(input logic [1:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] size,
                           input logic uns);
        valid_in = 1'b1; mem_op = op; alu_result = addr; reg_data = data;
        mem_size = size; mem_unsigned = uns;
    endtask

    // ---------------- reference model ----------------
    function automatic logic legal_m(input logic [31:0] addr, input logic [1:0] size);
        int n;
        n = 1 << size;
        return (size != 2'd3) && ((addr % n) == 0);
    endfunction

    function automatic logic [31:0] load_m(input logic [31:0] rdata, input logic [31:0] addr,
                                           input logic [1:0] size, input logic uns);
        longint unsigned v, span;
        int n, off;
        n = 1 << size;
        off = int'(addr % 4);
        span = 64'd1 << (8 * n);
        v = rdata;
        v = (v >> (8 * off)) % span;
        if (!uns && v >= (span / 2)) v = v - span;
        return v[31:0];
    endfunction

    function automatic logic [31:0] store_data_m(input logic [31:0] data, input logic [1:0] size);
        logic [31:0] r;
        int n;
        n = 1 << size;
        r = '0;
        for (int i = 0; i < 4; i++) r = r | (((data >> (8 * (i % n))) & 32'hFF) << (8 * i));
        return r;
    endfunction

    function automatic logic [3:0] store_strb_m(input logic [31:0] addr, input logic [1:0] size);
        logic [3:0] s;
        int n, off;
        n = 1 << size;
        off = int'(addr % 4);
        s = '0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) s[i] = 1'b1;
        return s;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; drive_idle();
        repeat (3) @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %0h expected 0", mem_req); end
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL reset_valid_out: got %0h expected 0", valid_out); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: got %0h expected 0", fault); end
        n_checks++; if (write_out !== 32'h0) begin n_errors++; $display("FAIL reset_write_out: got %0h expected 0", write_out); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin
            n_errors++; $display("FAIL reset_mem_bus: got addr=%0h wdata=%0h wstrb=%0h we=%0h expected all 0", mem_addr, mem_wdata, mem_wstrb, mem_we); end
        n_checks++; if (stall !== 1'b0 || dbg_state !== 1'b0) begin
            n_errors++; $display("FAIL reset_state: got stall=%0h state=%0h expected 0 0", stall, dbg_state); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_skip();
        present(OP_SKIP, 32'hDEADBEEF, 32'h0, 2'd2, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL skip_stall_in: got %0h expected 0", stall); end
        @(negedge clk); drive_idle(); #1;
        n_checks++; if (valid_out !== 1'b1 || write_out !== 32'hDEADBEEF || fault !== 1'b0) begin
            n_errors++; $display("FAIL skip_result: got v=%0h w=%0h f=%0h expected 1 deadbeef 0", valid_out, write_out, fault); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL skip_stall_out: got %0h expected 0", stall); end
        @(negedge clk);
        n_checks++; if (valid_out !== 1'b0 || write_out !== 32'hDEADBEEF) begin
            n_errors++; $display("FAIL skip_pulse_hold: got v=%0h w=%0h expected 0 deadbeef", valid_out, write_out); end
    endtask

    task automatic test_load_byte();
        logic [31:0] exp_w;
        int req_cycles;
        for (int u = 0; u < 2; u++) begin
            exp_w = load_m(32'h80FF1234, 32'h1003, 2'd0, u[0]);
            present(OP_LOAD, 32'h1003, 32'h0, 2'd0, u[0]);
            #1;
            n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL ldb_stall_accept: got %0h expected 1", stall); end
            req_cycles = 0;
            for (int c = 1; c <= 3; c++) begin
                @(negedge clk); drive_idle(); #1;
                if (mem_req === 1'b1 && stall === 1'b1) req_cycles++;
                if (c == 1) begin
                    n_checks++; if (mem_addr !== 32'h1000 || mem_wstrb !== 4'h0 || mem_we !== 1'b0) begin
                        n_errors++; $display("FAIL ldb_request: got addr=%0h wstrb=%0h we=%0h expected 1000 0 0", mem_addr, mem_wstrb, mem_we); end
                end
                if (c == 3) begin mem_ack = 1'b1; mem_rdata = 32'h80FF1234; end
            end
            @(negedge clk); mem_ack = 1'b0;
            n_checks++; if (req_cycles !== 3) begin n_errors++; $display("FAIL ldb_req_cycles: got %0d expected 3", req_cycles); end
            n_checks++; if (valid_out !== 1'b1 || write_out !== exp_w || fault !== 1'b0 || mem_req !== 1'b0) begin
                n_errors++; $display("FAIL ldb_result u=%0d: got v=%0h w=%0h f=%0h req=%0h expected 1 %0h 0 0", u, valid_out, write_out, fault, mem_req, exp_w); end
            @(negedge clk);
            n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL ldb_pulse: got %0h expected 0", valid_out); end
        end
    endtask

    task automatic test_store_half();
        present(OP_STORE, 32'h2002, 32'h1234ABCD, 2'd1, 1'b0);
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL sth_stall: got %0h expected 1", stall); end
        @(negedge clk); drive_idle();
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2000) begin
            n_errors++; $display("FAIL sth_request: got req=%0h we=%0h addr=%0h expected 1 1 2000", mem_req, mem_we, mem_addr); end
        n_checks++; if (mem_wdata !== store_data_m(32'h1234ABCD, 2'd1) || mem_wstrb !== store_strb_m(32'h2002, 2'd1)) begin
            n_errors++; $display("FAIL sth_lanes: got wdata=%0h wstrb=%0h expected abcdabcd c", mem_wdata, mem_wstrb); end
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk); mem_ack = 1'b0;
        n_checks++; if (valid_out !== 1'b1 || write_out !== 32'h0 || fault !== 1'b0 || mem_req !== 1'b0) begin
            n_errors++; $display("FAIL sth_result: got v=%0h w=%0h f=%0h req=%0h expected 1 0 0 0", valid_out, write_out, fault, mem_req); end
    endtask

    task automatic test_misaligned();
        logic [31:0] addrs [4] = '{32'h6, 32'h1, 32'h10, 32'h3};
        logic [1:0]  sizes [4] = '{2'd2, 2'd1, 2'd3, 2'd2};
        for (int i = 0; i < 4; i++) begin
            present(OP_SKIP, 32'h55550000 | i, 32'h0, 2'd0, 1'b0);
            @(negedge clk);
            present((i % 2 == 0) ? OP_LOAD : OP_STORE, addrs[i], 32'hCAFEF00D, sizes[i], 1'b0);
            #1;
            n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL mis_stall %0d: got %0h expected 0", i, stall); end
            @(negedge clk); drive_idle();
            n_checks++; if (valid_out !== 1'b1 || fault !== 1'b1 || write_out !== 32'h0 || mem_req !== 1'b0) begin
                n_errors++; $display("FAIL mis_result %0d: got v=%0h f=%0h w=%0h req=%0h expected 1 1 0 0", i, valid_out, fault, write_out, mem_req); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        present(OP_LOAD, 32'h40, 32'h0, 2'd2, 1'b0);
        @(negedge clk); drive_idle();
        n_checks++; if (mem_req !== 1'b1) begin n_errors++; $display("FAIL rstmid_req: got %0h expected 1", mem_req); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_checks++; if (mem_req !== 1'b0 || dbg_state !== 1'b0 || valid_out !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_after: got req=%0h state=%0h v=%0h expected 0 0 0", mem_req, dbg_state, valid_out); end
        mem_ack = 1'b1; mem_rdata = $urandom;
        @(negedge clk); mem_ack = 1'b0;
        n_checks++; if (valid_out !== 1'b0 || mem_req !== 1'b0 || dbg_state !== 1'b0) begin
            n_errors++; $display("FAIL rstmid_stray_ack: got v=%0h req=%0h state=%0h expected 0 0 0", valid_out, mem_req, dbg_state); end
        @(negedge clk);
        n_checks++; if (valid_out !== 1'b0) begin n_errors++; $display("FAIL rstmid_late: got %0h expected 0", valid_out); end
    endtask

    task automatic test_back_to_back();
        present(OP_LOAD, 32'h80, 32'h0, 2'd2, 1'b1);
        @(negedge clk);
        present(OP_SKIP, 32'h12345678, 32'h0, 2'd0, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h9ABCDEF0;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL b2b_stall_ack: got %0h expected 1", stall); end
        @(negedge clk); mem_ack = 1'b0; #1;
        n_checks++; if (valid_out !== 1'b1 || write_out !== 32'h9ABCDEF0 || stall !== 1'b0) begin
            n_errors++; $display("FAIL b2b_load: got v=%0h w=%0h stall=%0h expected 1 9abcdef0 0", valid_out, write_out, stall); end
        @(negedge clk); drive_idle();
        n_checks++; if (valid_out !== 1'b1 || write_out !== 32'h12345678) begin
            n_errors++; $display("FAIL b2b_skip: got v=%0h w=%0h expected 1 12345678", valid_out, write_out); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int found, high;
`ifdef MEM_TIMEOUT_EN
        present(OP_LOAD, 32'h100, 32'h0, 2'd2, 1'b0);
        found = 0; high = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk); drive_idle();
            if (valid_out === 1'b1) begin found = c; break; end
        end
        n_checks++; if (found !== 16) begin n_errors++; $display("FAIL timeout_cycle: got %0d expected 16", found); end
        n_checks++; if (fault !== 1'b1 || write_out !== 32'h0 || mem_req !== 1'b0) begin
            n_errors++; $display("FAIL timeout_result: got f=%0h w=%0h req=%0h expected 1 0 0", fault, write_out, mem_req); end
        @(negedge clk);
`else
        present(OP_LOAD, 32'h100, 32'h0, 2'd2, 1'b0);
        found = 0; high = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk); drive_idle();
            if (mem_req === 1'b1) high++;
            if (valid_out === 1'b1) found++;
        end
        n_checks++; if (high !== 100 || found !== 0) begin
            n_errors++; $display("FAIL wait_forever: got req_cycles=%0d pulses=%0d expected 100 0", high, found); end
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
        @(negedge clk); mem_ack = 1'b0;
        n_checks++; if (valid_out !== 1'b1 || write_out !== 32'h0BADF00D || fault !== 1'b0) begin
            n_errors++; $display("FAIL wait_late_ack: got v=%0h w=%0h f=%0h expected 1 badf00d 0", valid_out, write_out, fault); end
        @(negedge clk);
`endif
    endtask

    task automatic test_random();
        logic [1:0] op, size;
        logic [31:0] a, d, rd;
        logic uns, lg;
        logic [XLEN:0] exp_v;
        int delay;
        for (int t = 0; t < 60; t++) begin
            op = 2'($urandom_range(0, 2)); size = 2'($urandom_range(0, 3));
            a = $urandom; if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << size) - 32'd1);
            d = $urandom; rd = $urandom; uns = 1'($urandom_range(0, 1));
            delay = $urandom_range(0, 4);
            lg = legal_m(a, size);
            if (op == OP_SKIP) exp_q.push_back({1'b0, a});
            else if (!lg) exp_q.push_back({1'b1, 32'h0});
            else if (op == OP_LOAD) exp_q.push_back({1'b0, load_m(rd, a, size, uns)});
            else exp_q.push_back({1'b0, 32'h0});
            repeat ($urandom_range(0, 2)) @(negedge clk);
            mem_ack = 1'($urandom_range(0, 1));  // stray ack while IDLE
            mem_rdata = $urandom;
            present(op, a, d, size, uns);
            @(negedge clk); drive_idle(); mem_ack = 1'b0;
            if (op != OP_SKIP && lg) begin
                n_checks++; if (mem_req !== 1'b1 || mem_we !== (op == OP_STORE) || mem_addr !== (a & 32'hFFFFFFFC)) begin
                    n_errors++; $display("FAIL rnd_req t=%0d: got req=%0h we=%0h addr=%0h expected 1 %0h %0h", t, mem_req, mem_we, mem_addr, op == OP_STORE, a & 32'hFFFFFFFC); end
                n_checks++; if (mem_wstrb !== ((op == OP_STORE) ? store_strb_m(a, size) : 4'h0) ||
                                (op == OP_STORE && mem_wdata !== store_data_m(d, size))) begin
                    n_errors++; $display("FAIL rnd_lanes t=%0d: got wstrb=%0h wdata=%0h expected %0h %0h", t, mem_wstrb, mem_wdata, store_strb_m(a, size), store_data_m(d, size)); end
                for (int c = 0; c < delay; c++) begin
                    @(negedge clk);
                    n_checks++; if (mem_req !== 1'b1 || stall !== 1'b1 || mem_addr !== (a & 32'hFFFFFFFC) || valid_out !== 1'b0) begin
                        n_errors++; $display("FAIL rnd_hold t=%0d: got req=%0h stall=%0h addr=%0h v=%0h expected 1 1 %0h 0", t, mem_req, stall, mem_addr, valid_out, a & 32'hFFFFFFFC); end
                end
                mem_ack = 1'b1; mem_rdata = rd;
                @(negedge clk); mem_ack = 1'b0;
            end
            exp_v = exp_q.pop_front();
            n_checks++; if (valid_out !== 1'b1 || {fault, write_out} !== exp_v || mem_req !== 1'b0) begin
                n_errors++; $display("FAIL rnd_result t=%0d: got v=%0h f=%0h w=%0h req=%0h expected 1 %0h %0h 0", t, valid_out, fault, write_out, mem_req, exp_v[XLEN], exp_v[XLEN-1:0]); end
        end
        @(negedge clk);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_skip();
        test_load_byte();
        test_store_half();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
